// File: rtl/nand_selftest_pkg.sv
// Shared types and constants for the NAND exhaustive self-test block.
// Holds the sequencer state encoding and the golden NAND expectation.
package nand_selftest_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int NUM_VECTORS = 256;
  localparam int ERR_MAX     = 255;

  // Four 2-input NANDs on bit pairs; upper nibble is unused and reads zero.
  function automatic logic [7:0] nand_expect(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      r[i] = ~(v[2*i] & v[2*i+1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/nand_ref_model.sv
// Combinational golden model: expected NAND response for one vector.
// Wraps the package function so the top holds exactly one reference.
module nand_ref_model
  import nand_selftest_pkg::*;
(
  input  logic [7:0] vec,
  output logic [7:0] expected
);

  always_comb begin
    expected = nand_expect(vec);
  end

endmodule

// File: rtl/nand_selftest.sv
// Exhaustive 256-vector self-test sequencer for a 4x NAND design.
// Define NAND_SELFTEST_FIRST_FAIL_EN to capture the first failing vector.
module nand_selftest
  import nand_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] dut_ui_in,
  input  logic [7:0] dut_uo_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef NAND_SELFTEST_FIRST_FAIL_EN
  output logic [7:0] first_fail_vec,
  output logic [7:0] first_fail_obs,
  output logic       has_fail,
`endif
  output logic [7:0] err_count
);

  localparam logic [3:0] WAIT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_VEC  = 8'(NUM_VECTORS - 1);
  localparam logic [7:0] ERR_SAT   = 8'(ERR_MAX);

  state_t     state;
  logic [7:0] vec;
  logic [3:0] wait_cnt;
  logic [7:0] expected;
  logic       mismatch;
  logic [7:0] err_next;

  nand_ref_model u_ref (
    .vec      (vec),
    .expected (expected)
  );

  // Saturating error increment, evaluated in CHECK only.
  always_comb begin
    mismatch = (dut_uo_out != expected);
    err_next = err_count;
    if (mismatch && (err_count != ERR_SAT)) begin
      err_next = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= 8'h00;
      wait_cnt  <= 4'd0;
      dut_ui_in <= 8'h00;
      err_count <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef NAND_SELFTEST_FIRST_FAIL_EN
      first_fail_vec <= 8'h00;
      first_fail_obs <= 8'h00;
      has_fail       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            vec       <= 8'h00;
            err_count <= 8'h00;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef NAND_SELFTEST_FIRST_FAIL_EN
            first_fail_vec <= 8'h00;
            first_fail_obs <= 8'h00;
            has_fail       <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          dut_ui_in <= vec;
          wait_cnt  <= WAIT_LOAD;
          state     <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        CHECK: begin
          err_count <= err_next;
`ifdef NAND_SELFTEST_FIRST_FAIL_EN
          if (mismatch && !has_fail) begin
            first_fail_vec <= vec;
            first_fail_obs <= dut_uo_out;
            has_fail       <= 1'b1;
          end
`endif
          if (vec == LAST_VEC) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'h00);
          end else begin
            vec   <= vec + 8'd1;
            state <= DRIVE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_selftest.sv
// Directed/randomized bench for nand_selftest with a behavioural NAND model.
// Emulated NAND response supports correct, stuck-bit, forced and random faults.
module tb_nand_selftest;

  localparam int S   = 2;
  localparam int PER = S + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dut_ui_in;
  logic [7:0] dut_uo_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
`ifdef NAND_SELFTEST_FIRST_FAIL_EN
  logic [7:0] first_fail_vec;
  logic [7:0] first_fail_obs;
  logic       has_fail;
`endif

  int         checks = 0;
  int         errors = 0;
  int         mode   = 0;
  logic [7:0] mask [256];

  int         exp_err;
  int         exp_first_vec;
  int         exp_first_obs;
  int         exp_has;
  int         cycles;

  always #5 clk = ~clk;

  nand_selftest #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_ui_in  (dut_ui_in),
    .dut_uo_out (dut_uo_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
`ifdef NAND_SELFTEST_FIRST_FAIL_EN
    .first_fail_vec (first_fail_vec),
    .first_fail_obs (first_fail_obs),
    .has_fail       (has_fail),
`endif
    .err_count  (err_count)
  );

  // Arithmetic view: a pair NANDs to 0 only when its value equals 3.
  function automatic logic [7:0] ref_exp(input int v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (((v >> (2 * i)) % 4) != 3) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [7:0] fault_resp(input int v);
    case (mode)
      0:       return ref_exp(v);
      1:       return ref_exp(v) & 8'hFE;
      2:       return 8'hFF;
      default: return ref_exp(v) ^ mask[v];
    endcase
  endfunction

  always_comb begin
    case (mode)
      0:       dut_uo_out = ref_exp(int'(dut_ui_in));
      1:       dut_uo_out = ref_exp(int'(dut_ui_in)) & 8'hFE;
      2:       dut_uo_out = 8'hFF;
      default: dut_uo_out = ref_exp(int'(dut_ui_in)) ^ mask[dut_ui_in];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_run();
    logic [7:0] o;
    exp_err = 0;
    exp_has = 0;
    exp_first_vec = 0;
    exp_first_obs = 0;
    for (int v = 0; v < 256; v++) begin
      o = fault_resp(v);
      if (o != ref_exp(v)) begin
        exp_err++;
        if (exp_has == 0) begin
          exp_has = 1;
          exp_first_vec = v;
          exp_first_obs = int'(o);
        end
      end
    end
    if (exp_err > 255) exp_err = 255;
  endtask

  task automatic run(input int mid_start);
    int guard;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_clear", err_count, 0);
    cycles = 0;
    guard = 0;
    while (!done && guard < 5000) begin
      guard++;
      if (busy) begin
        cycles++;
        if (((cycles - 1) % PER != 0) && ($urandom_range(0, 31) == 0))
          check("ui_drive", dut_ui_in, (cycles - 1) / PER);
      end
      start = (mid_start > 0 && cycles == mid_start);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    model_run();
    check({tag, "_cycles"}, cycles, 256 * PER);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_count, exp_err);
    check({tag, "_pass"}, pass, (exp_err == 0));
    check({tag, "_ui_hold"}, dut_ui_in, 255);
`ifdef NAND_SELFTEST_FIRST_FAIL_EN
    check({tag, "_has"}, has_fail, exp_has);
    check({tag, "_ffv"}, first_fail_vec, exp_first_vec);
    check({tag, "_ffo"}, first_fail_obs, exp_first_obs);
`endif
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    for (int i = 0; i < 256; i++) mask[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ui", dut_ui_in, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // Correct response.
    run(0);
    check_result("good");
    repeat (2) @(negedge clk);
    check("done_hold", done, 1);
    check("done_ui_hold", dut_ui_in, 255);

    // Bit 0 stuck low.
    mode = 1;
    run(0);
    check_result("stuck0");

    // Start from DONE after a failing run, correct DUT now.
    mode = 0;
    run(0);
    check_result("rerun");

    // Forced 0xFF: every vector fails, count saturates.
    mode = 2;
    run(0);
    check_result("ff");

    // Random sparse corruption.
    mode = 3;
    for (int i = 0; i < 256; i++)
      mask[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    run(0);
    check_result("rand");

    // Start pulse mid-run is ignored.
    mode = 0;
    run(10);
    check_result("midstart");

    // Reset at cycle 300 abandons the run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err_count, 0);
    check("abort_ui", dut_ui_in, 0);
    repeat (3) @(negedge clk);
    check("abort_idle", busy, 0);

    // Reset beats start on the same edge.
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_win_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("rst_win_idle", busy, 0);

    run(0);
    check_result("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
